// File: rtl/multi_freq_gen.sv
// Multi-channel programmable clock generator: per-channel high/low/phase counts,
// phase-aligned start after period_stable, glitch-free reconfiguration at period boundaries.
module multi_freq_gen #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 16
) (
    input  logic                      clk,
    input  logic                      RST_N,
    input  logic                      PWRDWN,
    input  logic                      period_stable,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [3:0]                cfg_ch,
    input  logic [CNT_W-1:0]          cfg_high,
    input  logic [CNT_W-1:0]          cfg_low,
    input  logic [CNT_W-1:0]          cfg_phase,
    output logic                      cfg_err,
    output logic [N_CH-1:0]           out,
    output logic [N_CH*(CNT_W+1)-1:0] out_period,
    output logic                      running
);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE = 2'd0, ALIGN = 2'd1, RUN = 2'd2} state_t;

    state_t          state_reg, state_next;
    logic            gen_ok;
    logic            cfg_accept;
    logic            cfg_bad;
    logic            cfg_err_reg;
    logic [N_CH-1:0] started_vec;
    logic [N_CH-1:0] start_now;

    assign gen_ok     = period_stable && !PWRDWN;
    assign cfg_ready  = RST_N && !PWRDWN;
    assign cfg_accept = cfg_valid && cfg_ready;
    assign cfg_bad    = (cfg_high == '0) || (cfg_low == '0) || ({28'd0, cfg_ch} >= 32'(N_CH));
    assign cfg_err    = cfg_err_reg;

    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ALIGN completes on the edge where the last waiting channel fires
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (gen_ok) state_next = ALIGN;
            ALIGN: begin
                if (!gen_ok)
                    state_next = IDLE;
                else if (&(started_vec | start_now))
                    state_next = RUN;
            end
            RUN:     if (!gen_ok) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        running = (state_reg == RUN);
    end

    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            cfg_err_reg <= 1'b0;
        end else begin
            cfg_err_reg <= cfg_accept && cfg_bad;
        end
    end

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        logic             wr;
        logic [CNT_W-1:0] sh_high_reg, sh_low_reg, sh_phase_reg;
        logic [CNT_W-1:0] sh_high_next, sh_low_next, sh_phase_next;
        logic [CNT_W-1:0] act_high_reg, act_low_reg;
        logic [CNT_W-1:0] cnt_reg, phase_cnt_reg;
        logic             out_reg, started_reg;

        assign wr            = cfg_accept && !cfg_bad && (cfg_ch == 4'(gi));
        assign sh_high_next  = wr ? cfg_high  : sh_high_reg;
        assign sh_low_next   = wr ? cfg_low   : sh_low_reg;
        assign sh_phase_next = wr ? cfg_phase : sh_phase_reg;

        assign start_now[gi]   = !started_reg && (phase_cnt_reg == '0);
        assign started_vec[gi] = started_reg;
        assign out[gi]         = out_reg;
        assign out_period[gi*(CNT_W+1) +: (CNT_W+1)] = {1'b0, act_high_reg} + {1'b0, act_low_reg};

        // cnt_reg holds the remaining cycles of the current high or low half
        always_ff @(posedge clk or negedge RST_N) begin
            if (!RST_N) begin
                sh_high_reg   <= CNT_ONE;
                sh_low_reg    <= CNT_ONE;
                sh_phase_reg  <= '0;
                act_high_reg  <= CNT_ONE;
                act_low_reg   <= CNT_ONE;
                cnt_reg       <= '0;
                phase_cnt_reg <= '0;
                out_reg       <= 1'b0;
                started_reg   <= 1'b0;
            end else begin
                sh_high_reg  <= sh_high_next;
                sh_low_reg   <= sh_low_next;
                sh_phase_reg <= sh_phase_next;
                if (state_reg == IDLE) begin
                    act_high_reg  <= sh_high_next;
                    act_low_reg   <= sh_low_next;
                    phase_cnt_reg <= sh_phase_next;
                    cnt_reg       <= '0;
                    out_reg       <= 1'b0;
                    started_reg   <= 1'b0;
                end else if (!gen_ok) begin
                    cnt_reg       <= '0;
                    phase_cnt_reg <= '0;
                    out_reg       <= 1'b0;
                    started_reg   <= 1'b0;
                end else if (!started_reg) begin
                    if (phase_cnt_reg == '0) begin
                        act_high_reg <= sh_high_reg;
                        act_low_reg  <= sh_low_reg;
                        cnt_reg      <= sh_high_reg - CNT_ONE;
                        out_reg      <= 1'b1;
                        started_reg  <= 1'b1;
                    end else begin
                        phase_cnt_reg <= phase_cnt_reg - CNT_ONE;
                    end
                end else if (cnt_reg != '0) begin
                    cnt_reg <= cnt_reg - CNT_ONE;
                end else if (out_reg) begin
                    out_reg <= 1'b0;
                    cnt_reg <= act_low_reg - CNT_ONE;
                end else begin
                    // period boundary: adopt the shadow as it stood before this edge
                    act_high_reg <= sh_high_reg;
                    act_low_reg  <= sh_low_reg;
                    cnt_reg      <= sh_high_reg - CNT_ONE;
                    out_reg      <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_multi_freq_gen.sv
// Bench for multi_freq_gen: timeline model of each channel checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_multi_freq_gen;
    localparam int N  = 4;
    localparam int W  = 16;
    localparam int PW = N*(W+1);

    logic          clk = 1'b0;
    logic          RST_N = 1'b0;
    logic          PWRDWN = 1'b0;
    logic          period_stable = 1'b0;
    logic          cfg_valid = 1'b0;
    logic [3:0]    cfg_ch = '0;
    logic [W-1:0]  cfg_high = '0, cfg_low = '0, cfg_phase = '0;
    logic          cfg_ready, cfg_err, running;
    logic [N-1:0]  out;
    logic [PW-1:0] out_period;

    int n_tests = 0;
    int n_fail  = 0;

    multi_freq_gen #(.N_CH(N), .CNT_W(W)) dut (
        .clk(clk), .RST_N(RST_N), .PWRDWN(PWRDWN), .period_stable(period_stable),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
        .cfg_high(cfg_high), .cfg_low(cfg_low), .cfg_phase(cfg_phase),
        .cfg_err(cfg_err), .out(out), .out_period(out_period), .running(running)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1);
    end

    // ---------------- model: absolute-time view of each channel ----------------
    int cyc = 0;
    bit m_act = 0;
    bit m_err = 0;
    int sh_h[N], sh_l[N], sh_p[N], ac_h[N], ac_l[N], rise[N], pst[N];
    bit m_wr, m_bad, m_was_act;

    always @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            m_act = 0;
            m_err = 0;
            for (int k = 0; k < N; k++) begin
                sh_h[k] = 1; sh_l[k] = 1; sh_p[k] = 0;
                ac_h[k] = 1; ac_l[k] = 1; rise[k] = 0; pst[k] = 0;
            end
        end else begin
            cyc++;
            m_was_act = m_act;
            m_wr  = cfg_valid && !PWRDWN;
            m_bad = (cfg_high == 0) || (cfg_low == 0) || (cfg_ch >= N);
            m_err = m_wr && m_bad;
            if (m_act) begin
                if (!period_stable || PWRDWN) begin
                    m_act = 0;
                end else begin
                    for (int k = 0; k < N; k++) begin
                        if (cyc == rise[k] || (cyc > rise[k] && cyc == pst[k] + ac_h[k] + ac_l[k])) begin
                            ac_h[k] = sh_h[k];
                            ac_l[k] = sh_l[k];
                            pst[k]  = cyc;
                        end
                    end
                end
            end
            if (m_wr && !m_bad) begin
                sh_h[cfg_ch] = int'(cfg_high);
                sh_l[cfg_ch] = int'(cfg_low);
                sh_p[cfg_ch] = int'(cfg_phase);
            end
            if (!m_was_act) begin
                for (int k = 0; k < N; k++) begin
                    ac_h[k] = sh_h[k];
                    ac_l[k] = sh_l[k];
                end
                if (period_stable && !PWRDWN) begin
                    m_act = 1;
                    for (int k = 0; k < N; k++) begin
                        rise[k] = cyc + sh_p[k] + 1;
                        pst[k]  = rise[k];
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- per-cycle compare against the model ----------------
    logic [N-1:0]  c_out;
    logic [PW-1:0] c_per;
    logic          c_run;
    int            c_maxr;

    always @(posedge clk) begin
        #1;
        c_out  = '0;
        c_per  = '0;
        c_maxr = 0;
        for (int k = 0; k < N; k++) begin
            if (m_act && cyc >= rise[k] && (cyc - pst[k]) < ac_h[k]) c_out[k] = 1'b1;
            if (rise[k] > c_maxr) c_maxr = rise[k];
            c_per[k*(W+1) +: (W+1)] = 17'(ac_h[k] + ac_l[k]);
        end
        c_run = m_act && (cyc >= c_maxr);
        check("model_out", out, c_out);
        check("model_running", running, c_run);
        check("model_cfg_err", cfg_err, m_err);
        check("model_cfg_ready", cfg_ready, RST_N && !PWRDWN);
        check("model_out_period", out_period, c_per);
    end

    // ---------------- directed stimulus ----------------
    function automatic logic [W:0] per(input int k);
        return out_period[k*(W+1) +: (W+1)];
    endfunction

    task automatic to_edge(input int e);
        while (cyc < e) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cfg_write(input int e, input int ch, input int h, input int l, input int p);
        to_edge(e - 1);
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_ch    = 4'(ch);
        cfg_high  = 16'(h);
        cfg_low   = 16'(l);
        cfg_phase = 16'(p);
        to_edge(e);
    endtask

    task automatic cfg_idle();
        cfg_valid = 1'b0;
    endtask

    task automatic set_ps(input int e, input logic v);
        to_edge(e - 1);
        @(negedge clk);
        period_stable = v;
    endtask

    // ch0 3/5 phase 0, ch1 2/2 phase 4, entry edge t
    task automatic align_checks(input int t, input string tag);
        to_edge(t);
        check({tag, "_entry_out"}, out, 4'h0);
        to_edge(t + 1);
        check({tag, "_ch0_rise"}, out[0], 1'b1);
        check({tag, "_ch1_wait"}, out[1], 1'b0);
        check({tag, "_run_early"}, running, 1'b0);
        to_edge(t + 4);
        check({tag, "_ch0_fall"}, out[0], 1'b0);
        to_edge(t + 5);
        check({tag, "_ch1_rise"}, out[1], 1'b1);
        check({tag, "_running"}, running, 1'b1);
        check({tag, "_per0"}, per(0), 17'd8);
        check({tag, "_per1"}, per(1), 17'd4);
        to_edge(t + 9);
        check({tag, "_ch0_rise2"}, out[0], 1'b1);
    endtask

    int t0, t1, r, b, w, p, d;

    initial begin
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        check("rst_out", out, 4'h0);
        check("rst_running", running, 1'b0);
        check("rst_ready", cfg_ready, 1'b0);
        check("rst_err", cfg_err, 1'b0);
        check("rst_period", out_period, {4{17'd2}});
        @(negedge clk);
        RST_N = 1'b1;

        // defaults: all channels toggle every cycle
        set_ps(10, 1'b1);
        to_edge(10);
        check("def_align_run", running, 1'b0);
        to_edge(11);
        check("def_out_hi", out, 4'hF);
        check("def_running", running, 1'b1);
        to_edge(12);
        check("def_out_lo", out, 4'h0);
        to_edge(13);
        check("def_out_hi2", out, 4'hF);
        check("def_period", per(0), 17'd2);

        set_ps(16, 1'b0);
        to_edge(16);
        check("drop_out", out, 4'h0);
        check("drop_running", running, 1'b0);

        // IDLE writes land in the active config immediately
        cfg_write(18, 0, 3, 5, 0);
        cfg_write(19, 1, 2, 2, 4);
        cfg_idle();
        check("idle_copy_ch0", per(0), 17'd8);
        check("idle_copy_ch1", per(1), 17'd4);

        t0 = 22;
        set_ps(t0, 1'b1);
        align_checks(t0, "align1");

        // drop in RUN, then realign identically
        set_ps(t0 + 22, 1'b0);
        to_edge(t0 + 22);
        check("drop2_out", out, 4'h0);
        check("drop2_running", running, 1'b0);
        t1 = t0 + 26;
        set_ps(t1, 1'b1);
        align_checks(t1, "align2");

        // mid-high rewrite of ch0: current 3/5 period completes first
        r = t1 + 25;
        cfg_write(r + 1, 0, 1, 1, 0);
        cfg_idle();
        to_edge(r + 2);
        check("rw_still_hi", out[0], 1'b1);
        to_edge(r + 3);
        check("rw_lo", out[0], 1'b0);
        to_edge(r + 7);
        check("rw_lo_end", out[0], 1'b0);
        check("rw_per_old", per(0), 17'd8);
        to_edge(r + 8);
        check("rw_new_rise", out[0], 1'b1);
        check("rw_per_new", per(0), 17'd2);
        to_edge(r + 9);
        check("rw_new_lo", out[0], 1'b0);
        to_edge(r + 10);
        check("rw_new_hi", out[0], 1'b1);

        // write on ch1's own boundary edge takes effect one period later
        b = t1 + 41;
        cfg_write(b, 1, 3, 3, 0);
        cfg_idle();
        check("bnd_per_old", per(1), 17'd4);
        check("bnd_hi", out[1], 1'b1);
        to_edge(b + 2);
        check("bnd_lo", out[1], 1'b0);
        to_edge(b + 4);
        check("bnd_new_hi", out[1], 1'b1);
        check("bnd_per_new", per(1), 17'd6);
        to_edge(b + 7);
        check("bnd_new_lo", out[1], 1'b0);

        // rejected writes
        w = b + 9;
        cfg_write(w, 2, 0, 4, 0);
        cfg_idle();
        check("err_high0", cfg_err, 1'b1);
        check("err_high0_per", per(2), 17'd2);
        to_edge(w + 1);
        check("err_clear", cfg_err, 1'b0);
        cfg_write(w + 3, 4, 5, 5, 0);
        cfg_idle();
        check("err_ch", cfg_err, 1'b1);
        cfg_write(w + 5, 2, 3, 0, 0);
        cfg_idle();
        check("err_low0", cfg_err, 1'b1);
        to_edge(w + 6);
        check("err_clear2", cfg_err, 1'b0);
        check("err_low0_per", per(2), 17'd2);

        // back-to-back writes: last wins; ch1 phase change deferred to next ALIGN
        cfg_write(w + 8, 2, 4, 4, 0);
        cfg_write(w + 9, 2, 2, 1, 0);
        cfg_write(w + 10, 1, 3, 3, 2);
        cfg_idle();
        to_edge(w + 30);
        check("b2b_per2", per(2), 17'd3);
        check("phase_wr_per1", per(1), 17'd6);

        // power-down for 5 cycles with a write attempt
        p = w + 32;
        to_edge(p - 1);
        @(negedge clk);
        PWRDWN = 1'b1;
        to_edge(p);
        check("pd_out", out, 4'h0);
        check("pd_running", running, 1'b0);
        check("pd_ready", cfg_ready, 1'b0);
        cfg_write(p + 2, 3, 7, 7, 0);
        cfg_idle();
        check("pd_no_err", cfg_err, 1'b0);
        to_edge(p + 4);
        @(negedge clk);
        PWRDWN = 1'b0;
        to_edge(p + 5);
        check("pd_cfg_kept", per(3), 17'd2);
        check("pd_ready_back", cfg_ready, 1'b1);
        to_edge(p + 7);
        check("pd_realign_wait", running, 1'b0);
        to_edge(p + 8);
        check("pd_realign_run", running, 1'b1);
        check("pd_ch1_phase2", out[1], 1'b1);

        // drop and write on the same edge: copied to active one edge later
        d = p + 20;
        to_edge(d - 1);
        @(negedge clk);
        period_stable = 1'b0;
        cfg_valid = 1'b1;
        cfg_ch    = 4'd3;
        cfg_high  = 16'd4;
        cfg_low   = 16'd4;
        cfg_phase = 16'd0;
        to_edge(d);
        cfg_idle();
        check("sim_out", out, 4'h0);
        check("sim_per_old", per(3), 17'd2);
        to_edge(d + 1);
        check("sim_per_new", per(3), 17'd8);

        // reset in the middle of generation
        set_ps(d + 3, 1'b1);
        to_edge(d + 20);
        @(negedge clk);
        RST_N = 1'b0;
        #1;
        check("mrst_out", out, 4'h0);
        check("mrst_running", running, 1'b0);
        @(posedge clk);
        #1;
        check("mrst_period", out_period, {4{17'd2}});
        check("mrst_ready", cfg_ready, 1'b0);
        @(negedge clk);
        RST_N = 1'b1;
        to_edge(cyc + 15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/multi_freq_gen.md
MULTI_FREQ_GEN -- requirements
Module: multi_freq_gen

Interface
REQ-001 Parameter N_CH, default 4, number of independent output channels (1..16).
REQ-002 Parameter CNT_W, default 16, width of high/low/phase counts in clk cycles.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 RST_N  input  1  asynchronous, active-low reset.
REQ-005 PWRDWN  input  1  power-down; synchronous, outputs and counters held low.
REQ-006 period_stable  input  1  reference is trusted; gates start of generation.
REQ-007 cfg_valid  input  1  config write request.
REQ-008 cfg_ready  output  1  config write accepted when cfg_valid && cfg_ready.
REQ-009 cfg_ch  input  4  target channel index.
REQ-010 cfg_high, cfg_low, cfg_phase  input  CNT_W each  high cycles, low cycles, start delay in cycles.
REQ-011 cfg_err  output  1  one-cycle pulse on rejected write.
REQ-012 out  output  N_CH  generated clock per channel.
REQ-013 out_period  output  N_CH*(CNT_W+1)  active period (high+low) per channel, channel k at bits [k*(CNT_W+1) +: CNT_W+1].
REQ-014 running  output  1  high in RUN state.

Function
REQ-015 Global FSM states IDLE, ALIGN, RUN; IDLE -> ALIGN on edge sampling period_stable=1 and PWRDWN=0.
REQ-016 ALIGN: each channel loads phase counter with its active phase and counts down one per cycle; channel k out rises on the edge PHASE_k+1 cycles after the ALIGN-entry edge (phase 0 -> out high on first edge after entry).
REQ-017 ALIGN -> RUN on the edge where the last channel has started; with all phases 0, RUN entered together with the first high edge.
REQ-018 Per channel once started: out high for exactly HIGH cycles, then low for exactly LOW cycles, repeating; out_period = HIGH+LOW computed in CNT_W+1 bits without overflow.
REQ-019 period_stable sampled 0 in ALIGN or RUN -> IDLE; all out low and counters cleared on that same edge.
REQ-020 PWRDWN=1 in any state -> IDLE, all out low, cfg_ready=0; writes ignored without cfg_err.
REQ-021 Each channel holds shadow and active config; accepted write updates shadow only.
REQ-022 Shadow -> active copy: immediately (same edge) while IDLE; in ALIGN/RUN only at that channel's period boundary (edge where out would rise), so no truncated high or low phase is ever produced.
REQ-023 Write with cfg_high=0, cfg_low=0 or cfg_ch>=N_CH is rejected: shadow unchanged, cfg_err=1 for the following cycle.
REQ-024 cfg_ready=1 whenever PWRDWN=0; two back-to-back writes to the same channel: last one wins at the boundary.
REQ-025 Write coinciding with a period boundary of the same channel: the new value takes effect from the next boundary; the boundary copies the pre-write shadow.
REQ-026 Phase counter only used in ALIGN; phase changes written during RUN take effect only at the next IDLE -> ALIGN.
REQ-027 Simultaneous period_stable drop and cfg write: write accepted into shadow, copied to active in IDLE on the next edge.

Reset
REQ-028 RST_N=0 asynchronously forces IDLE, out=0, running=0, cfg_err=0, cfg_ready=0 while asserted.
REQ-029 Reset config of every channel: high=1, low=1, phase=0 (shadow and active), out_period=2.
REQ-030 Reset deassertion mid-operation resumes from IDLE; generation restarts only via period_stable per REQ-015.

Verification
REQ-031 Reset, period_stable=1 at cycle 10 with defaults -> all out toggle every cycle from cycle 11, running=1 at cycle 11, out_period=2.
REQ-032 Ch0 high=3 low=5 phase=0, ch1 high=2 low=2 phase=4 -> ch0 rises cycle t0+1, period 8; ch1 rises t0+5, period 4; running at t0+5.
REQ-033 In RUN, ch0 high=3 low=5 rewritten to high=1 low=1 mid-high -> current 3/5 period completes intact, then 1/1 from next rising edge.
REQ-034 Write cfg_high=0 or cfg_ch=N_CH -> cfg_err pulse 1 cycle, out_period unchanged.
REQ-035 period_stable drops in RUN -> all out low next edge, running=0; reassert -> phase alignment repeated exactly as REQ-032.
REQ-036 PWRDWN=1 for 5 cycles in RUN, write attempted -> out low, cfg_ready=0, no cfg_err, config unchanged after release.
